perspective_project: RTL and testbench

Projects one camera-space vertex (x, y, z, signed fixed point) to integer screen pixel coordinates by dividing x and y by z. Feeds the shared iterative fixed-point divider `div`, issuing x/z and then y/z. It scales each quotient by the focal length and recentres it on the screen. Sits between the vertex transform stage (upstream, valid/ready) and the rasteriser (downstream, valid/ready).

---
 rtl/proj_pkg.sv | 27 ++
 rtl/div.sv | 89 ++++++++
 rtl/perspective_project.sv | 178 +++++++++++++++++
 tb/tb_perspective_project.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared types and default geometry for the perspective projection stage.
package proj_pkg;

   localparam int unsigned PROJ_WIDTH    = 16;
   localparam int unsigned PROJ_FBITS    = 8;
   localparam int unsigned PROJ_SCREEN_W = 320;
   localparam int unsigned PROJ_SCREEN_H = 240;
   localparam int unsigned PROJ_FOCAL    = 160;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DIV_X  = 3'd1,
      WAIT_X = 3'd2,
      DIV_Y  = 3'd3,
      WAIT_Y = 3'd4,
      SCALE  = 3'd5,
      OUT    = 3'd6
   } state_e;

   // Captured camera-space vertex; fields sized for the default WIDTH.
   typedef struct packed {
      logic [PROJ_WIDTH-1:0] x;
      logic [PROJ_WIDTH-1:0] y;
      logic [PROJ_WIDTH-1:0] z;
   } vertex_t;

endpackage

// File: rtl/div.sv
// Iterative signed fixed-point divider: val = (a << FBITS) / b, truncated toward zero.
// Done arrives WIDTH+FBITS+2 cycles after the start cycle; divide-by-zero finishes early.
module div #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned FBITS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] val,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned NB = WIDTH + FBITS;
   localparam int unsigned CW = $clog2(NB + 1);

   logic             busy;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic [NB-1:0]    quo;
   logic             neg;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             fits;
   logic [NB-1:0]    lim;
   logic [WIDTH-1:0] q_lo;

   assign abs_a   = a[WIDTH-1] ? WIDTH'(0) - a : a;
   assign abs_b   = b[WIDTH-1] ? WIDTH'(0) - b : b;
   assign shifted = {rem, quo[NB-1]};
   assign fits    = shifted >= {1'b0, dvs};
   assign trial   = WIDTH'(shifted - {1'b0, dvs});
   // Negative results may reach one step further than positive ones.
   assign lim     = neg ? (NB'(1) << (WIDTH - 1)) : ((NB'(1) << (WIDTH - 1)) - NB'(1));
   assign q_lo    = quo[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         rem  <= '0;
         dvs  <= '0;
         quo  <= '0;
         neg  <= 1'b0;
         done <= 1'b0;
         val  <= '0;
         dbz  <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            if (b == '0) begin
               done <= 1'b1;
               dbz  <= 1'b1;
               ovf  <= 1'b0;
               val  <= '0;
            end else begin
               busy <= 1'b1;
               cnt  <= CW'(NB);
               rem  <= '0;
               dvs  <= abs_b;
               quo  <= {abs_a, FBITS'(0)};
               neg  <= a[WIDTH-1] ^ b[WIDTH-1];
            end
         end else if (busy) begin
            if (cnt != '0) begin
               cnt <= cnt - CW'(1);
               rem <= fits ? trial : shifted[WIDTH-1:0];
               quo <= {quo[NB-2:0], fits};
            end else begin
               busy <= 1'b0;
               done <= 1'b1;
               dbz  <= 1'b0;
               ovf  <= quo > lim;
               val  <= neg ? WIDTH'(0) - q_lo : q_lo;
            end
         end
      end
   end

endmodule

// File: rtl/perspective_project.sv
// Projects a camera-space vertex to screen pixels via one shared divider (x/z then y/z).
// Optional PROJ_CLIP_EN adds the near-plane reject and the screen-bounds clip.
module perspective_project
   import proj_pkg::*;
#(
   parameter int unsigned WIDTH    = PROJ_WIDTH,
   parameter int unsigned FBITS    = PROJ_FBITS,
   parameter int unsigned SCREEN_W = PROJ_SCREEN_W,
   parameter int unsigned SCREEN_H = PROJ_SCREEN_H,
   parameter int unsigned FOCAL    = PROJ_FOCAL
`ifdef PROJ_CLIP_EN
  ,parameter logic [WIDTH-1:0] NEAR = WIDTH'(16'h0040)
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            x,
   input  logic [WIDTH-1:0]            y,
   input  logic [WIDTH-1:0]            z,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(SCREEN_W)-1:0] px,
   output logic [$clog2(SCREEN_H)-1:0] py,
   output logic [WIDTH-1:0]            out_z,
   output logic                        clipped
);

   localparam int unsigned PXW = $clog2(SCREEN_W);
   localparam int unsigned PYW = $clog2(SCREEN_H);
   localparam int unsigned PW  = WIDTH + 16;
   localparam int unsigned SW  = WIDTH + 17;

   state_e                  state_q, state_d;
   vertex_t                 vtx_q, vtx_d;
   logic signed [WIDTH-1:0] qx_q, qx_d, qy_q, qy_d;
   logic                    err_q, err_d;
   logic                    div_start, div_start_d;
   logic                    in_ready_d, out_valid_d, clipped_d;
   logic [PXW-1:0]          px_d;
   logic [PYW-1:0]          py_d;
   logic [WIDTH-1:0]        out_z_d;

   logic [WIDTH-1:0]        div_a, div_b, div_val;
   logic                    div_done, div_dbz, div_ovf;

   logic signed [PW-1:0]    prod_x, prod_y, sx, sy;
   logic signed [SW-1:0]    px_full, py_full;
   logic                    scale_bad;

   // Operands come straight from the captured vertex, so they hold until done.
   assign div_a = (state_q == DIV_Y || state_q == WAIT_Y) ? vtx_q.y : vtx_q.x;
   assign div_b = vtx_q.z;

   div #(.WIDTH(WIDTH), .FBITS(FBITS)) u_div (
      .clk   (clk),
      .rst   (rst),
      .start (div_start),
      .a     (div_a),
      .b     (div_b),
      .done  (div_done),
      .val   (div_val),
      .dbz   (div_dbz),
      .ovf   (div_ovf)
   );

   assign prod_x  = $signed(PW'(FOCAL)) * $signed(PW'(qx_q));
   assign prod_y  = $signed(PW'(FOCAL)) * $signed(PW'(qy_q));
   assign sx      = prod_x >>> FBITS;
   assign sy      = prod_y >>> FBITS;
   assign px_full = $signed(SW'(SCREEN_W / 2)) + SW'(sx);
   assign py_full = $signed(SW'(SCREEN_H / 2)) - SW'(sy);

`ifdef PROJ_CLIP_EN
   logic near_rej, out_of_bounds;
   assign near_rej      = $signed(z) <= $signed(NEAR);
   assign out_of_bounds = (px_full < 0) || (px_full > $signed(SW'(SCREEN_W - 1))) ||
                          (py_full < 0) || (py_full > $signed(SW'(SCREEN_H - 1)));
   assign scale_bad     = err_q | out_of_bounds;
`else
   assign scale_bad     = err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         vtx_q     <= '0;
         qx_q      <= '0;
         qy_q      <= '0;
         err_q     <= 1'b0;
         div_start <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         px        <= '0;
         py        <= '0;
         out_z     <= '0;
         clipped   <= 1'b0;
      end else begin
         state_q   <= state_d;
         vtx_q     <= vtx_d;
         qx_q      <= qx_d;
         qy_q      <= qy_d;
         err_q     <= err_d;
         div_start <= div_start_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         px        <= px_d;
         py        <= py_d;
         out_z     <= out_z_d;
         clipped   <= clipped_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      vtx_d     = vtx_q;
      qx_d      = qx_q;
      qy_d      = qy_q;
      err_d     = err_q;
      px_d      = px;
      py_d      = py;
      out_z_d   = out_z;
      clipped_d = clipped;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               vtx_d = vertex_t'{x: x, y: y, z: z};
               err_d = 1'b0;
`ifdef PROJ_CLIP_EN
               if (near_rej) begin
                  state_d   = OUT;
                  clipped_d = 1'b1;
                  px_d      = '0;
                  py_d      = '0;
                  out_z_d   = z;
               end else
`endif
               state_d = DIV_X;
            end
         end
         DIV_X:  state_d = WAIT_X;
         WAIT_X: begin
            if (div_done) begin
               qx_d    = div_val;
               err_d   = err_q | div_dbz | div_ovf;
               state_d = DIV_Y;
            end
         end
         DIV_Y:  state_d = WAIT_Y;
         WAIT_Y: begin
            if (div_done) begin
               qy_d    = div_val;
               err_d   = err_q | div_dbz | div_ovf;
               state_d = SCALE;
            end
         end
         SCALE: begin
            clipped_d = scale_bad;
            px_d      = scale_bad ? '0 : PXW'(px_full);
            py_d      = scale_bad ? '0 : PYW'(py_full);
            out_z_d   = vtx_q.z;
            state_d   = OUT;
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Handshake flags and the start pulse follow the state being entered.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == OUT);
      div_start_d = (state_d == DIV_X) || (state_d == DIV_Y);
   end

endmodule

// File: tb/tb_perspective_project.sv
// Bench for perspective_project: directed and random vertices against an arithmetic model.
// Expectations follow PROJ_CLIP_EN when it is defined for the build.
module tb_perspective_project;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic [15:0] x, y, z;
   logic        in_ready, out_valid, clipped;
   logic [8:0]  px;
   logic [7:0]  py;
   logic [15:0] out_z;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;

   logic [15:0] tv [4][3] = '{
      '{16'h0100, 16'h0080, 16'h0200},
      '{16'h0100, 16'h0100, 16'h0000},
      '{16'h0040, 16'hFFC0, 16'h0020},
      '{16'h0400, 16'h0000, 16'h0100}
   };

   perspective_project dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .z         (z),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .px        (px),
      .py        (py),
      .out_z     (out_z),
      .clipped   (clipped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (dut.div_start === 1'b1) start_cnt++;

   function automatic longint floor256(input longint p);
      return (p >= 0) ? p / 256 : -((-p + 255) / 256);
   endfunction

   // kind: 0 = both divisions valid, 1 = near-plane reject, 2 = divider error
   task automatic model(input logic [15:0] xi, yi, zi,
                        output int epx, output int epy, output bit eclip, output int kind);
      longint xs, ys, zs, qx, qy, pxl, pyl;
      bit bad;
      xs = longint'($signed(xi));
      ys = longint'($signed(yi));
      zs = longint'($signed(zi));
      bad = 1'b0; kind = 0; pxl = 0; pyl = 0;
`ifdef PROJ_CLIP_EN
      if (zs <= 64) begin bad = 1'b1; kind = 1; end
`endif
      if (!bad) begin
         if (zs == 0) begin
            bad = 1'b1; kind = 2;
         end else begin
            qx = (xs * 256) / zs;
            qy = (ys * 256) / zs;
            if (qx > 32767 || qx < -32768 || qy > 32767 || qy < -32768) begin
               bad = 1'b1; kind = 2;
            end else begin
               pxl = 160 + floor256(160 * qx);
               pyl = 120 - floor256(160 * qy);
`ifdef PROJ_CLIP_EN
               if (pxl < 0 || pxl > 319 || pyl < 0 || pyl > 239) bad = 1'b1;
`endif
            end
         end
      end
      eclip = bad;
      epx   = bad ? 0 : int'(pxl & 511);
      epy   = bad ? 0 : int'(pyl & 255);
   endtask

   task automatic send(input logic [15:0] xi, yi, zi);
      int g;
      g = 0;
      while (in_ready !== 1'b1 && g < 100) begin @(posedge clk); #1; g++; end
      in_valid = 1'b1; x = xi; y = yi; z = zi;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; z = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || clipped !== 1'b0 ||
          px !== 9'd0 || py !== 8'd0 || out_z !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset: in_ready=%b out_valid=%b clipped=%b px=%0d py=%0d out_z=%h, required 1 0 0 0 0 0000",
                  in_ready, out_valid, clipped, px, py, out_z);
      end
   endtask

   task automatic test_directed();
      int epx, epy, kind, lat, s0;
      bit eclip;
      for (int i = 0; i < 4; i++) begin
         model(tv[i][0], tv[i][1], tv[i][2], epx, epy, eclip, kind);
         s0 = start_cnt;
         send(tv[i][0], tv[i][1], tv[i][2]);
         wait_out(lat);
         if (i == 0) begin
            n_checks++;
            if (px !== 9'd240 || py !== 8'd80 || clipped !== 1'b0) begin
               n_fail++;
               $display("FAIL spec_vector: px=%0d py=%0d clipped=%b, required 240 80 0", px, py, clipped);
            end
         end
         n_checks++;
         if (px !== 9'(epx) || py !== 8'(epy) || clipped !== eclip || out_z !== tv[i][2]) begin
            n_fail++;
            $display("FAIL directed[%0d]: px=%0d py=%0d clipped=%b out_z=%h, required %0d %0d %b %h",
                     i, px, py, clipped, out_z, epx, epy, eclip, tv[i][2]);
         end
         if (kind != 2) begin
            n_checks++;
            if (lat != ((kind == 1) ? 0 : 55)) begin
               n_fail++;
               $display("FAIL directed_latency[%0d]: %0d cycles after accept, required %0d",
                        i, lat, (kind == 1) ? 0 : 55);
            end
         end
         n_checks++;
         if ((start_cnt - s0) != ((kind == 1) ? 0 : 2)) begin
            n_fail++;
            $display("FAIL directed_starts[%0d]: %0d divider starts, required %0d",
                     i, start_cnt - s0, (kind == 1) ? 0 : 2);
         end
         release_out();
      end
   endtask

   task automatic test_random();
      int epx, epy, kind, lat;
      bit eclip;
      logic [15:0] rx, ry, rz;
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0:       rz = 16'($urandom_range(0, 16'h0080));
            1, 2:    rz = 16'($urandom_range(16'h0100, 16'h0800));
            default: rz = 16'($urandom);
         endcase
         rx = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1536)) - 768);
         ry = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 1536)) - 768);
         model(rx, ry, rz, epx, epy, eclip, kind);
         send(rx, ry, rz);
         wait_out(lat);
         n_checks++;
         if (px !== 9'(epx) || py !== 8'(epy) || clipped !== eclip || out_z !== rz) begin
            n_fail++;
            $display("FAIL random[%0d] x=%h y=%h z=%h: px=%0d py=%0d clipped=%b out_z=%h, required %0d %0d %b %h",
                     i, rx, ry, rz, px, py, clipped, out_z, epx, epy, eclip, rz);
         end
         if (kind != 2) begin
            n_checks++;
            if (lat != ((kind == 1) ? 0 : 55)) begin
               n_fail++;
               $display("FAIL random_latency[%0d]: %0d, required %0d", i, lat, (kind == 1) ? 0 : 55);
            end
         end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      send(16'h0100, 16'h0080, 16'h0200);
      wait_out(lat);
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || px !== 9'd240 || py !== 8'd80 ||
             clipped !== 1'b0 || out_z !== 16'h0200) begin
            n_fail++;
            $display("FAIL hold[%0d]: out_valid=%b in_ready=%b px=%0d py=%0d clipped=%b out_z=%h, required 1 0 240 80 0 0200",
                     c, out_valid, in_ready, px, py, clipped, out_z);
         end
         @(posedge clk); #1;
      end
      release_out();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL after_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      in_valid = 1'b1; x = 16'h0080; y = 16'hFF80; z = 16'h0100;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_out(lat);
      n_checks++;
      if (lat != 55 || px !== 9'd240 || py !== 8'd200) begin
         n_fail++;
         $display("FAIL next_accept: latency=%0d px=%0d py=%0d, required 55 240 200", lat, px, py);
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat, epx, epy, kind;
      bit eclip, seen;
      send(16'h0100, 16'h0080, 16'h0200);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      end
      seen = 1'b0;
      repeat (70) begin @(posedge clk); #1; if (out_valid === 1'b1) seen = 1'b1; end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL abandoned: out_valid=1 after reset, required 0");
      end
      model(16'hFF00, 16'h0100, 16'h0200, epx, epy, eclip, kind);
      send(16'hFF00, 16'h0100, 16'h0200);
      wait_out(lat);
      n_checks++;
      if (lat != 55 || px !== 9'(epx) || py !== 8'(epy) || clipped !== eclip || px !== 9'd80) begin
         n_fail++;
         $display("FAIL post_reset: latency=%0d px=%0d py=%0d clipped=%b, required 55 %0d %0d %b",
                  lat, px, py, clipped, epx, epy, eclip);
      end
      release_out();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
